// File: rtl/mips_pkg.sv
// ----------------------------------------------------------------------------
// mips_pkg
//   Shared constants for the multi-cycle MIPS core.
//   - OPC_*   : primary opcodes (instr[31:26]) understood by the decoder
//   - FUNCT_* : R-type function codes (instr[5:0])
//   - ALU_*   : operation codes carried on alu_op to the execute stage
//   - state_t : decode-stage FSM encoding (IDLE / ISSUE)
// ----------------------------------------------------------------------------
package mips_pkg;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_BNE   = 6'b000101;
    localparam logic [5:0] OPC_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;
    localparam logic [5:0] FUNCT_MUL = 6'b011000;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_SLT = 4'd4;
    localparam logic [3:0] ALU_MUL = 4'd5;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

endpackage

// File: rtl/reg_file.sv
// ----------------------------------------------------------------------------
// reg_file
//   Architectural GPR file: 2**REG_AW registers of DATA_W bits.
//   Two asynchronous read ports, one synchronous write port.
//   Register 0 is hardwired to zero: writes to it are dropped, reads return 0.
//   Write-first bypass is not done here; the decode stage handles it.
// Ports
//   clock            : write clock (posedge)
//   reset            : asynchronous active-high, clears every register
//   we/waddr/wdata   : write port
//   raddr_a/rdata_a  : read port A
//   raddr_b/rdata_b  : read port B
// ----------------------------------------------------------------------------
module reg_file #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [REG_AW-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [REG_AW-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b
);

    localparam int NREG = 1 << REG_AW;

    logic [DATA_W-1:0] regs [NREG];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a == '0) ? '0 : regs[raddr_a];
    assign rdata_b = (raddr_b == '0) ? '0 : regs[raddr_b];

endmodule

// File: rtl/decode_stage.sv
// ----------------------------------------------------------------------------
// decode_stage
//   Stage 2 of the multi-cycle MIPS core. Splits the instruction from fetch into
//   fields, reads the GPR file (with write-first bypass from stage 5),
//   sign-extends the immediate and generates the control word. All results are
//   registered on the edge that samples stage2 and presented with the stage3
//   token.
// Ports
//   clock, reset        : clock (posedge) and asynchronous active-high reset
//   stage2, instruction : token + instruction word from fetch
//   wb_en/addr/data     : GPR write-back from stage 5
//   stage3              : token to execute, high exactly while FSM is in ISSUE
//   rs_data, rt_data    : GPR[rs], GPR[rt]
//   imm_ext             : sign-extended instr[15:0]
//   dst_reg             : rd (R-type), rt (addi/lw), else 0
//   alu_op + control    : reg_write, mem_read, mem_write, alu_src, branch,
//                         branch_ne, jump
//   jump_target         : instr[PC_W-1:0] for j, else 0
//   illegal             : unsupported opcode/funct
//   state_dbg           : current FSM state
// Token semantics: stage2 is a one-cycle valid with no back-pressure. Each
//   cycle stage2 is high at a posedge, one instruction is captured and stage3 is
//   high for the following cycle. Execute has no ready: it must take every
//   token. Outputs hold their last values while stage3 is low.
// ----------------------------------------------------------------------------
module decode_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int PC_W   = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stage2,
    input  logic [DATA_W-1:0] instruction,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              stage3,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [DATA_W-1:0] imm_ext,
    output logic [REG_AW-1:0] dst_reg,
    output logic [3:0]        alu_op,
    output logic              reg_write,
    output logic              mem_read,
    output logic              mem_write,
    output logic              alu_src,
    output logic              branch,
    output logic              branch_ne,
    output logic              jump,
    output logic [PC_W-1:0]   jump_target,
    output logic              illegal,
    output state_t            state_dbg
);

    // ------------------------------------------------------------------
    // Instruction fields
    // ------------------------------------------------------------------
    logic [5:0]        opcode;
    logic [5:0]        funct;
    logic [REG_AW-1:0] rs_idx;
    logic [REG_AW-1:0] rt_idx;
    logic [REG_AW-1:0] rd_idx;

    assign opcode = instruction[31:26];
    assign funct  = instruction[5:0];
    assign rs_idx = REG_AW'(instruction[25:21]);
    assign rt_idx = REG_AW'(instruction[20:16]);
    assign rd_idx = REG_AW'(instruction[15:11]);

    // ------------------------------------------------------------------
    // Register file and write-first bypass
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] rf_rs;
    logic [DATA_W-1:0] rf_rt;
    logic [DATA_W-1:0] rs_fwd;
    logic [DATA_W-1:0] rt_fwd;

    reg_file #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_reg_file (
        .clock   (clock),
        .reset   (reset),
        .we      (wb_en),
        .waddr   (wb_addr),
        .wdata   (wb_data),
        .raddr_a (rs_idx),
        .rdata_a (rf_rs),
        .raddr_b (rt_idx),
        .rdata_b (rf_rt)
    );

    // A write landing on the same edge as the decode must be visible to it;
    // reg 0 is excluded so a dropped write cannot leak through the bypass.
    assign rs_fwd = (wb_en && (wb_addr == rs_idx) && (rs_idx != '0)) ? wb_data : rf_rs;
    assign rt_fwd = (wb_en && (wb_addr == rt_idx) && (rt_idx != '0)) ? wb_data : rf_rt;

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    logic [3:0]        c_alu_op;
    logic              c_reg_write;
    logic              c_mem_read;
    logic              c_mem_write;
    logic              c_alu_src;
    logic              c_branch;
    logic              c_branch_ne;
    logic              c_jump;
    logic              c_illegal;
    logic [REG_AW-1:0] c_dst_reg;
    logic [PC_W-1:0]   c_jump_target;

    always_comb begin
        c_alu_op      = ALU_ADD;
        c_reg_write   = 1'b0;
        c_mem_read    = 1'b0;
        c_mem_write   = 1'b0;
        c_alu_src     = 1'b0;
        c_branch      = 1'b0;
        c_branch_ne   = 1'b0;
        c_jump        = 1'b0;
        c_illegal     = 1'b0;
        c_dst_reg     = '0;
        c_jump_target = '0;
        case (opcode)
            OPC_RTYPE: begin
                c_reg_write = 1'b1;
                c_dst_reg   = rd_idx;
                case (funct)
                    FUNCT_ADD: c_alu_op = ALU_ADD;
                    FUNCT_SUB: c_alu_op = ALU_SUB;
                    FUNCT_AND: c_alu_op = ALU_AND;
                    FUNCT_OR:  c_alu_op = ALU_OR;
                    FUNCT_SLT: c_alu_op = ALU_SLT;
                    FUNCT_MUL: c_alu_op = ALU_MUL;
                    default: begin
                        // Unknown funct: squash everything the R-type path set.
                        c_illegal   = 1'b1;
                        c_reg_write = 1'b0;
                        c_dst_reg   = '0;
                    end
                endcase
            end
            OPC_ADDI: begin
                c_reg_write = 1'b1;
                c_alu_src   = 1'b1;
                c_dst_reg   = rt_idx;
            end
            OPC_LW: begin
                c_reg_write = 1'b1;
                c_mem_read  = 1'b1;
                c_alu_src   = 1'b1;
                c_dst_reg   = rt_idx;
            end
            OPC_SW: begin
                c_mem_write = 1'b1;
                c_alu_src   = 1'b1;
            end
            OPC_BEQ: begin
                c_alu_op = ALU_SUB;
                c_branch = 1'b1;
            end
            OPC_BNE: begin
                c_alu_op    = ALU_SUB;
                c_branch    = 1'b1;
                c_branch_ne = 1'b1;
            end
            OPC_J: begin
                c_jump        = 1'b1;
                c_jump_target = instruction[PC_W-1:0];
            end
            default: c_illegal = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: ISSUE for every cycle following an edge where stage2 was high
    // ------------------------------------------------------------------
    state_t state;
    state_t next_state;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (stage2)  next_state = ISSUE;
            ISSUE:   if (!stage2) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Decoded from the state register so an asynchronous reset drops it at once.
    assign stage3    = (state == ISSUE);
    assign state_dbg = state;

    // ------------------------------------------------------------------
    // Output registers: load on every accepted token, hold otherwise
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rs_data     <= '0;
            rt_data     <= '0;
            imm_ext     <= '0;
            dst_reg     <= '0;
            alu_op      <= ALU_ADD;
            reg_write   <= 1'b0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            alu_src     <= 1'b0;
            branch      <= 1'b0;
            branch_ne   <= 1'b0;
            jump        <= 1'b0;
            jump_target <= '0;
            illegal     <= 1'b0;
        end else if (stage2) begin
            rs_data     <= rs_fwd;
            rt_data     <= rt_fwd;
            imm_ext     <= {{(DATA_W-16){instruction[15]}}, instruction[15:0]};
            dst_reg     <= c_dst_reg;
            alu_op      <= c_alu_op;
            reg_write   <= c_reg_write;
            mem_read    <= c_mem_read;
            mem_write   <= c_mem_write;
            alu_src     <= c_alu_src;
            branch      <= c_branch;
            branch_ne   <= c_branch_ne;
            jump        <= c_jump;
            jump_target <= c_jump_target;
            illegal     <= c_illegal;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// ----------------------------------------------------------------------------
// tb_decode_stage
//   Directed bench for decode_stage. Inputs change 1ns after a rising edge and
//   outputs are sampled 1ns after the next rising edge.
//   ctl vector order: {reg_write, mem_read, mem_write, alu_src,
//                      branch, branch_ne, jump, illegal}
// ----------------------------------------------------------------------------
module tb_decode_stage;
    import mips_pkg::*;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int PC_W   = 4;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic              stage2      = 1'b0;
    logic [DATA_W-1:0] instruction = '0;
    logic              wb_en       = 1'b0;
    logic [REG_AW-1:0] wb_addr     = '0;
    logic [DATA_W-1:0] wb_data     = '0;

    logic              stage3;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm_ext;
    logic [REG_AW-1:0] dst_reg;
    logic [3:0]        alu_op;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              alu_src;
    logic              branch;
    logic              branch_ne;
    logic              jump;
    logic [PC_W-1:0]   jump_target;
    logic              illegal;
    state_t            state_dbg;

    logic [7:0] ctl;
    assign ctl = {reg_write, mem_read, mem_write, alu_src, branch, branch_ne, jump, illegal};

    int checks   = 0;
    int failures = 0;

    decode_stage #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW),
        .PC_W   (PC_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .stage2      (stage2),
        .instruction (instruction),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .stage3      (stage3),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .imm_ext     (imm_ext),
        .dst_reg     (dst_reg),
        .alu_op      (alu_op),
        .reg_write   (reg_write),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .alu_src     (alu_src),
        .branch      (branch),
        .branch_ne   (branch_ne),
        .jump        (jump),
        .jump_target (jump_target),
        .illegal     (illegal),
        .state_dbg   (state_dbg)
    );

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] r_instr(input logic [4:0] rs, input logic [4:0] rt,
                                            input logic [4:0] rd, input logic [5:0] fn);
        return {6'b000000, rs, rt, rd, 5'd0, fn};
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; stage2 = 1'b1; instruction = 32'h00632020;
        wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'd5;
        tick(); tick();
        checks++;
        if (stage3 !== 1'b0 || state_dbg !== IDLE) begin
            failures++;
            $display("FAIL reset_token stage3=%b state=%0d expected 0/IDLE", stage3, state_dbg);
        end
        checks++;
        if ({rs_data, rt_data, imm_ext} !== 96'd0 || dst_reg !== 5'd0 || alu_op !== 4'd0) begin
            failures++;
            $display("FAIL reset_data rs=%h rt=%h imm=%h dst=%0d alu=%0d expected all 0",
                     rs_data, rt_data, imm_ext, dst_reg, alu_op);
        end
        checks++;
        if (ctl !== 8'd0 || jump_target !== 4'd0) begin
            failures++;
            $display("FAIL reset_ctl ctl=%b jt=%h expected 0", ctl, jump_target);
        end
        reset = 1'b0; stage2 = 1'b0; wb_en = 1'b0;
        tick();
        // every GPR must read back zero (r1 had a write blocked by reset)
        for (int i = 1; i < 32; i++) begin
            logic [4:0] r;
            r = i[4:0];
            stage2 = 1'b1; instruction = r_instr(r, r, 5'd1, FUNCT_ADD);
            tick();
            checks++;
            if (rs_data !== 32'd0 || rt_data !== 32'd0) begin
                failures++;
                $display("FAIL reset_gpr r%0d rs=%h rt=%h expected 0", i, rs_data, rt_data);
            end
        end
        stage2 = 1'b0;
        tick();
    endtask

    task automatic test_basic_add();
        wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'd7;
        tick();
        wb_en = 1'b0; stage2 = 1'b1; instruction = 32'h00632020;  // add $4,$3,$3
        checks++;
        if (stage3 !== 1'b0) begin
            failures++;
            $display("FAIL add_pre_token stage3=%b expected 0", stage3);
        end
        tick();
        stage2 = 1'b0;
        checks++;
        if (stage3 !== 1'b1 || state_dbg !== ISSUE) begin
            failures++;
            $display("FAIL add_token stage3=%b state=%0d expected 1/ISSUE", stage3, state_dbg);
        end
        checks++;
        if (rs_data !== 32'd7 || rt_data !== 32'd7 || dst_reg !== 5'd4) begin
            failures++;
            $display("FAIL add_data rs=%h rt=%h dst=%0d expected 7/7/4", rs_data, rt_data, dst_reg);
        end
        checks++;
        if (alu_op !== ALU_ADD || ctl !== 8'b1000_0000 || imm_ext !== 32'h00002020) begin
            failures++;
            $display("FAIL add_ctl alu=%0d ctl=%b imm=%h expected 0/10000000/00002020",
                     alu_op, ctl, imm_ext);
        end
        tick();
        checks++;
        if (stage3 !== 1'b0 || rs_data !== 32'd7 || dst_reg !== 5'd4) begin
            failures++;
            $display("FAIL add_hold stage3=%b rs=%h dst=%0d expected 0/7/4", stage3, rs_data, dst_reg);
        end
    endtask

    task automatic test_wb_idle();
        wb_en = 1'b1; wb_addr = 5'd4; wb_data = 32'h1234;
        tick();
        wb_en = 1'b0;
        checks++;
        if (stage3 !== 1'b0 || rs_data !== 32'd7 || rt_data !== 32'd7 || dst_reg !== 5'd4) begin
            failures++;
            $display("FAIL wb_idle_hold stage3=%b rs=%h rt=%h dst=%0d expected 0/7/7/4",
                     stage3, rs_data, rt_data, dst_reg);
        end
        stage2 = 1'b1; instruction = 32'h00803020;  // add $6,$4,$0
        tick();
        stage2 = 1'b0;
        checks++;
        if (rs_data !== 32'h1234 || rt_data !== 32'd0 || dst_reg !== 5'd6) begin
            failures++;
            $display("FAIL wb_idle_read rs=%h rt=%h dst=%0d expected 1234/0/6", rs_data, rt_data, dst_reg);
        end
        tick();
    endtask

    task automatic test_bypass();
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEAD;
        stage2 = 1'b1; instruction = 32'h8CA2FFFC;  // lw $2,-4($5)
        tick();
        wb_en = 1'b0; stage2 = 1'b0;
        checks++;
        if (rs_data !== 32'hDEAD || rt_data !== 32'd0) begin
            failures++;
            $display("FAIL bypass_data rs=%h rt=%h expected DEAD/0", rs_data, rt_data);
        end
        checks++;
        if (imm_ext !== 32'hFFFFFFFC || dst_reg !== 5'd2 || alu_op !== ALU_ADD || ctl !== 8'b1101_0000) begin
            failures++;
            $display("FAIL bypass_lw imm=%h dst=%0d alu=%0d ctl=%b expected FFFFFFFC/2/0/11010000",
                     imm_ext, dst_reg, alu_op, ctl);
        end
        tick();
        // write must also have landed in the file
        stage2 = 1'b1; instruction = r_instr(5'd5, 5'd3, 5'd7, FUNCT_ADD);
        tick();
        stage2 = 1'b0;
        checks++;
        if (rs_data !== 32'hDEAD || rt_data !== 32'd7) begin
            failures++;
            $display("FAIL bypass_stored rs=%h rt=%h expected DEAD/7", rs_data, rt_data);
        end
        tick();
    endtask

    task automatic test_reg0();
        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'd9;
        tick();
        // second write to reg 0 coincides with the decode: bypass must not fire
        stage2 = 1'b1; instruction = r_instr(5'd0, 5'd0, 5'd8, FUNCT_ADD);
        tick();
        wb_en = 1'b0; stage2 = 1'b0;
        checks++;
        if (rs_data !== 32'd0 || rt_data !== 32'd0) begin
            failures++;
            $display("FAIL reg0_read rs=%h rt=%h expected 0/0", rs_data, rt_data);
        end
        tick();
    endtask

    task automatic test_alu_table();
        logic [5:0]  fn_tab  [6] = '{FUNCT_ADD, FUNCT_SUB, FUNCT_AND, FUNCT_OR, FUNCT_SLT, FUNCT_MUL};
        logic [3:0]  alu_tab [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
        for (int i = 0; i < 6; i++) begin
            stage2 = 1'b1; instruction = r_instr(5'd3, 5'd5, 5'd9, fn_tab[i]);
            tick();
            checks++;
            if (alu_op !== alu_tab[i] || ctl !== 8'b1000_0000 || dst_reg !== 5'd9 || stage3 !== 1'b1) begin
                failures++;
                $display("FAIL rtype_%0d alu=%0d ctl=%b dst=%0d s3=%b expected %0d/10000000/9/1",
                         i, alu_op, ctl, dst_reg, stage3, alu_tab[i]);
            end
        end
        stage2 = 1'b1; instruction = {OPC_ADDI, 5'd3, 5'd10, 16'h8001};
        tick();
        checks++;
        if (alu_op !== ALU_ADD || ctl !== 8'b1001_0000 || dst_reg !== 5'd10 || imm_ext !== 32'hFFFF8001) begin
            failures++;
            $display("FAIL addi alu=%0d ctl=%b dst=%0d imm=%h expected 0/10010000/10/FFFF8001",
                     alu_op, ctl, dst_reg, imm_ext);
        end
        instruction = {OPC_SW, 5'd3, 5'd5, 16'h0008};
        tick();
        stage2 = 1'b0;
        checks++;
        if (alu_op !== ALU_ADD || ctl !== 8'b0011_0000 || dst_reg !== 5'd0 || imm_ext !== 32'h8) begin
            failures++;
            $display("FAIL sw alu=%0d ctl=%b dst=%0d imm=%h expected 0/00110000/0/8",
                     alu_op, ctl, dst_reg, imm_ext);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        stage2 = 1'b1; instruction = {OPC_BEQ, 5'd3, 5'd5, 16'h0010};
        tick();
        checks++;
        if (stage3 !== 1'b1 || alu_op !== ALU_SUB || ctl !== 8'b0000_1000 || dst_reg !== 5'd0 ||
            rs_data !== 32'd7 || rt_data !== 32'hDEAD) begin
            failures++;
            $display("FAIL b2b_beq s3=%b alu=%0d ctl=%b dst=%0d rs=%h rt=%h expected 1/1/00001000/0/7/DEAD",
                     stage3, alu_op, ctl, dst_reg, rs_data, rt_data);
        end
        instruction = {OPC_BNE, 5'd3, 5'd5, 16'hFFF0};
        tick();
        checks++;
        if (stage3 !== 1'b1 || alu_op !== ALU_SUB || ctl !== 8'b0000_1100 || imm_ext !== 32'hFFFFFFF0) begin
            failures++;
            $display("FAIL b2b_bne s3=%b alu=%0d ctl=%b imm=%h expected 1/1/00001100/FFFFFFF0",
                     stage3, alu_op, ctl, imm_ext);
        end
        instruction = {OPC_J, 26'h5};
        tick();
        stage2 = 1'b0;
        checks++;
        if (stage3 !== 1'b1 || alu_op !== ALU_ADD || ctl !== 8'b0000_0010 || jump_target !== 4'h5 ||
            dst_reg !== 5'd0) begin
            failures++;
            $display("FAIL b2b_j s3=%b alu=%0d ctl=%b jt=%h dst=%0d expected 1/0/00000010/5/0",
                     stage3, alu_op, ctl, jump_target, dst_reg);
        end
        tick();
        checks++;
        if (stage3 !== 1'b0 || state_dbg !== IDLE || jump_target !== 4'h5) begin
            failures++;
            $display("FAIL b2b_end s3=%b state=%0d jt=%h expected 0/IDLE/5", stage3, state_dbg, jump_target);
        end
    endtask

    task automatic test_illegal();
        stage2 = 1'b1; instruction = {6'b111111, 26'h0};
        tick();
        stage2 = 1'b0;
        checks++;
        if (stage3 !== 1'b1 || alu_op !== ALU_ADD || ctl !== 8'b0000_0001 || dst_reg !== 5'd0 ||
            jump_target !== 4'd0) begin
            failures++;
            $display("FAIL illegal_op s3=%b alu=%0d ctl=%b dst=%0d jt=%h expected 1/0/00000001/0/0",
                     stage3, alu_op, ctl, dst_reg, jump_target);
        end
        tick();
        checks++;
        if (stage3 !== 1'b0) begin
            failures++;
            $display("FAIL illegal_pulse stage3=%b expected 0", stage3);
        end
        // R-type with unsupported funct (sll encoding)
        stage2 = 1'b1; instruction = r_instr(5'd3, 5'd5, 5'd9, 6'b000000);
        tick();
        stage2 = 1'b0;
        checks++;
        if (alu_op !== ALU_ADD || ctl !== 8'b0000_0001 || dst_reg !== 5'd0) begin
            failures++;
            $display("FAIL illegal_funct alu=%0d ctl=%b dst=%0d expected 0/00000001/0",
                     alu_op, ctl, dst_reg);
        end
        tick();
    endtask

    task automatic test_reset_mid_issue();
        stage2 = 1'b1; instruction = 32'h00632020;
        tick();
        checks++;
        if (stage3 !== 1'b1) begin
            failures++;
            $display("FAIL rmi_token stage3=%b expected 1", stage3);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (stage3 !== 1'b0 || rs_data !== 32'd0 || reg_write !== 1'b0) begin
            failures++;
            $display("FAIL rmi_async s3=%b rs=%h rw=%b expected 0/0/0", stage3, rs_data, reg_write);
        end
        tick();
        reset = 1'b0;
        tick();
        // GPRs were cleared by the reset
        instruction = 32'h00632020;
        tick();
        stage2 = 1'b0;
        checks++;
        if (rs_data !== 32'd0 || stage3 !== 1'b1) begin
            failures++;
            $display("FAIL rmi_gpr rs=%h s3=%b expected 0/1", rs_data, stage3);
        end
        tick();
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_basic_add();
        test_wb_idle();
        test_bypass();
        test_reg0();
        test_alu_table();
        test_back_to_back();
        test_illegal();
        test_reset_mid_issue();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
